uart_tx_engine: RTL

//   UART transmitter, the peer of the UART RX path. It accepts one byte per

---
 rtl/uart_tx_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART transmitter. Accepts one byte per valid/ready handshake and
//   serialises it LSB-first on uart_tx: start bit, 8 data bits, optional
//   parity bit, then 1 or 2 stop bits. Each bit cell lasts 16 pulses of the
//   shared 16x-baud tick.
//
// Parameters
//   PARITY_EN   1: parity bit after the data bits, 0: none
//   PARITY_ODD  1: odd parity, 0: even parity (ignored when PARITY_EN=0)
//   STOP_BITS   1 or 2 stop bits (values other than 2 behave as 1)
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   baud_x16_tick  in   1-cycle pulse at 16x the baud rate
//   tx_in_valid    in   upstream has a byte on tx_in_data
//   tx_in_ready    out  engine can take a byte (state == S_IDLE)
//   tx_in_data     in   byte to send, sampled only when the handshake fires
//   uart_tx        out  registered serial line, idle high
//   tx_busy        out  high whenever a frame is in flight
//   fsm_state      out  current FSM state, for debug and checkers
//
// Handshake: a byte transfers on a clock edge where tx_in_valid and
// tx_in_ready are both high. Ready is a pure function of the state; valid
// without ready is ignored and there is no skid buffer.
module uart_tx_engine #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_x16_tick,
  input  logic       tx_in_valid,
  output logic       tx_in_ready,
  input  logic [7:0] tx_in_data,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);
  // stop_count value at which the final stop cell ends
  localparam logic [1:0] LAST_STOP = (STOP_BITS == 2) ? 2'd1 : 2'd0;

  state_t     state;
  logic [3:0] tick_counter;
  logic [2:0] bit_index;
  logic [7:0] shift_reg;
  logic [1:0] stop_count;
  logic       parity_bit;
  logic       tx_fire;
  logic       bit_end_fire;

  assign tx_in_ready  = (state == S_IDLE);
  assign tx_busy      = (state != S_IDLE);
  assign fsm_state    = state;
  assign tx_fire      = tx_in_valid && tx_in_ready;
  assign bit_end_fire = baud_x16_tick && (tick_counter == 4'd15);

  // uart_tx is loaded with the level of the state being entered, so the line
  // moves on the same edge as the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      uart_tx      <= 1'b1;
      tick_counter <= 4'd0;
      bit_index    <= 3'd0;
      shift_reg    <= 8'd0;
      stop_count   <= 2'd0;
      parity_bit   <= 1'b0;
    end else begin
      // Held at 0 while idle so the first cell counts 16 ticks from acceptance;
      // wraps 15->0 naturally so every later cell starts at 0 as well.
      if (state == S_IDLE)
        tick_counter <= 4'd0;
      else if (baud_x16_tick)
        tick_counter <= tick_counter + 4'd1;

      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_fire) begin
            shift_reg  <= tx_in_data;
            parity_bit <= (^tx_in_data) ^ PAR_ODD;
            bit_index  <= 3'd0;
            stop_count <= 2'd0;
            state      <= S_START;
            uart_tx    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end_fire) begin
            state     <= S_DATA;
            bit_index <= 3'd0;
            uart_tx   <= shift_reg[0];
          end
        end

        S_DATA: begin
          if (bit_end_fire) begin
            bit_index <= bit_index + 3'd1;
            if (bit_index == 3'd7) begin
              if (HAS_PAR) begin
                state   <= S_PARITY;
                uart_tx <= parity_bit;
              end else begin
                state      <= S_STOP;
                stop_count <= 2'd0;
                uart_tx    <= 1'b1;
              end
            end else begin
              uart_tx <= shift_reg[bit_index + 3'd1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end_fire) begin
            state      <= S_STOP;
            stop_count <= 2'd0;
            uart_tx    <= 1'b1;
          end
        end

        S_STOP: begin
          uart_tx <= 1'b1;
          if (bit_end_fire) begin
            if (stop_count == LAST_STOP) begin
              state      <= S_IDLE;
              stop_count <= 2'd0;
            end else begin
              stop_count <= stop_count + 2'd1;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
